free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter FL_NUM, default `FL_NUM (32); number of free-list entries, equal to PRF_NUM - ARF_NUM.
REQ-002 SHALL have parameter ARF_NUM, default `ARF_NUM (32); number of architectural registers mapped at reset.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port dispatch_en_i, input, 1: dispatch allocates one destination tag this cycle.
REQ-006 SHALL have port retire_en_i, input, 1: ROB retires an insn whose old tag is freed this cycle.
REQ-007 SHALL have port retire_tag_i, input, `PRF_IDX_W: freed physical tag.
REQ-008 SHALL have port br_state_i, input, `BR_STATE_W: branch resolution state from ROB.
REQ-009 SHALL have port rc_head_i, input, `FL_PTR_W+1: recovery head from the branch stack.
REQ-010 SHALL have port free_tag_o, output, `PRF_IDX_W: tag at current head.
REQ-011 SHALL have port head_o, output, `FL_PTR_W+1: current head pointer (wrap bit is MSB), backed up by the branch stack.
REQ-012 SHALL have port empty_o, output, 1: no free tag is available.
REQ-013 SHALL have port count_o, output, `FL_PTR_W+1: number of free entries, 0..FL_NUM.

Function
REQ-014 SHALL implement a circular FIFO of FL_NUM tags with head/tail pointers of `FL_PTR_W+1 bits; the MSB is the wrap bit.
REQ-015 SHALL compute count_o = tail - head, modulo 2^(`FL_PTR_W+1).
REQ-016 SHALL assert empty_o when head equals tail, all bits including wrap.
REQ-017 SHALL drive free_tag_o combinationally from entry[head[`FL_PTR_W-1:0]]; it is valid whenever empty_o=0.
REQ-018 SHALL, on dispatch_en_i=1 and empty_o=0, advance head by 1 at the clock edge (pop).
REQ-019 SHALL ignore dispatch_en_i when empty_o=1; head is unchanged. Dispatch stalling upstream is the ROB/dispatch's job.
REQ-020 SHALL, on retire_en_i=1, write retire_tag_i to entry[tail] and advance tail by 1; the new tag is visible no earlier than the next cycle (no bypass to free_tag_o).
REQ-021 SHALL, on simultaneous pop and push with empty_o=0, perform both; count is unchanged.
REQ-022 SHALL, on simultaneous pop and push with empty_o=1, perform the push only; empty_o deasserts the next cycle.
REQ-023 SHALL, when br_state_i == `BR_PR_WRONG, load head <= rc_head_i and ignore dispatch_en_i that cycle; tail and entries are not modified by recovery.
REQ-024 SHALL, on recovery coincident with retire_en_i, also perform the push: tail advances and the entry is written.
REQ-025 SHALL NOT alter state for br_state_i values other than `BR_PR_WRONG.
REQ-026 SHALL wrap pointers from FL_NUM-1 to 0 with the wrap bit toggled; FL_NUM is a power of two.
REQ-027 SHALL treat a push when count_o == FL_NUM as illegal, covered by a simulation assertion; state behaviour is then undefined.

Reset
REQ-028 SHALL, while rst=0 (asynchronous), set entry[i] = ARF_NUM+i for i in 0..FL_NUM-1.
REQ-029 SHALL, while rst=0, set head=0 and tail={1'b1,0...}; outputs are then free_tag_o=ARF_NUM, head_o=0, count_o=FL_NUM, empty_o=0.
REQ-030 SHALL let reset override any in-flight pop, push or recovery.

Structure
REQ-031 SHALL take PRF_NUM, ARF_NUM, FL_NUM, FL_PTR_W, PRF_IDX_W, BR_STATE_W and BR_PR_WRONG from the shared sys_defs package/header; no local redefinition.
REQ-032 SHALL be a single flat module with no sub-module; entry storage is a flop array.

Verification
REQ-033 SHALL cover reset: rst=0 then 1 -> free_tag_o=32, head_o=6'b000000, count_o=32, empty_o=0.
REQ-034 SHALL cover drain: 32 consecutive dispatches -> tags 32..63 in order, then empty_o=1, count_o=0, head_o=6'b100000; a 33rd dispatch leaves head unchanged.
REQ-035 SHALL cover empty-case simultaneous events: from empty, dispatch_en_i=1 and retire 5 in the same cycle -> next cycle empty_o=0, free_tag_o=5, count_o=1.
REQ-036 SHALL cover recovery: head_o=3 captured, 4 more pops (head=7), then BR_PR_WRONG with rc_head_i=3 and dispatch_en_i=1 -> head_o=3, free_tag_o=35, count_o=29.
REQ-037 SHALL cover wrap: push/pop across index 31->0 -> wrap bit toggles, FIFO order preserved, count_o exact.
REQ-038 SHALL cover mid-operation reset: rst=0 asserted during simultaneous pop+push -> immediate return to the REQ-029 values.

Source files
------------

// File: rtl/sys_defs_pkg.sv
// Shared machine parameters for the rename stage: register file sizes,
// free-list pointer widths and the branch resolution encoding from the ROB.
package sys_defs_pkg;

  localparam int PRF_NUM    = 64;
  localparam int ARF_NUM    = 32;
  localparam int FL_NUM     = PRF_NUM - ARF_NUM;
  localparam int FL_PTR_W   = $clog2(FL_NUM);
  localparam int PRF_IDX_W  = $clog2(PRF_NUM);
  localparam int BR_STATE_W = 2;

  typedef enum logic [BR_STATE_W-1:0] {
    BR_NONE       = 2'd0,
    BR_PR_CORRECT = 2'd1,
    BR_PR_WRONG   = 2'd2
  } br_state_e;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of free tags, popped at dispatch,
// pushed at retire, with head rollback on branch misprediction.
module free_list #(
  parameter int FL_NUM  = sys_defs_pkg::FL_NUM,
  parameter int ARF_NUM = sys_defs_pkg::ARF_NUM
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                dispatch_en_i,
  input  logic                                retire_en_i,
  input  logic [sys_defs_pkg::PRF_IDX_W-1:0]  retire_tag_i,
  input  logic [sys_defs_pkg::BR_STATE_W-1:0] br_state_i,
  input  logic [sys_defs_pkg::FL_PTR_W:0]     rc_head_i,
  output logic [sys_defs_pkg::PRF_IDX_W-1:0]  free_tag_o,
  output logic [sys_defs_pkg::FL_PTR_W:0]     head_o,
  output logic                                empty_o,
  output logic [sys_defs_pkg::FL_PTR_W:0]     count_o
);

  localparam int IW = sys_defs_pkg::FL_PTR_W;
  localparam int TW = sys_defs_pkg::PRF_IDX_W;
  localparam logic [IW:0] FULL_COUNT = FL_NUM[IW:0];

  logic [TW-1:0] entries [FL_NUM];
  logic [IW:0]   head;
  logic [IW:0]   tail;
  logic          empty;
  logic          recover;
  logic          pop;
  logic          push;

  assign empty   = (head == tail);
  assign recover = (br_state_i == sys_defs_pkg::BR_PR_WRONG);
  assign pop     = dispatch_en_i && !empty && !recover;
  assign push    = retire_en_i;

  assign free_tag_o = entries[head[IW-1:0]];
  assign head_o     = head;
  assign empty_o    = empty;
  assign count_o    = tail - head;

  // Reset leaves the FIFO full of the tags not claimed by the architectural map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= {1'b1, {IW{1'b0}}};
    end else begin
      if (recover) begin
        head <= rc_head_i;
      end else if (pop) begin
        head <= head + 1'b1;
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_NUM; i++) begin
        entries[i] <= TW'(ARF_NUM + i);
      end
    end else if (push) begin
      entries[tail[IW-1:0]] <= retire_tag_i;
    end
  end

  // A push into a full list would overwrite a tag that is still free.
  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(retire_en_i && (count_o == FULL_COUNT)));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reference model plus a scoreboard of granted tags.
module tb_free_list;
  import sys_defs_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dispatch_en_i = 1'b0;
  logic       retire_en_i = 1'b0;
  logic [5:0] retire_tag_i = '0;
  logic [1:0] br_state_i = 2'd0;
  logic [5:0] rc_head_i = '0;
  logic [5:0] free_tag_o;
  logic [5:0] head_o;
  logic       empty_o;
  logic [5:0] count_o;

  logic [5:0] mem [32];
  logic [5:0] mhead;
  logic [5:0] mtail;
  logic [5:0] exp_q [$];
  logic [5:0] cap_head;
  logic [5:0] t;
  int errors = 0;
  int checks = 0;

  free_list #(.FL_NUM(32), .ARF_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .dispatch_en_i(dispatch_en_i), .retire_en_i(retire_en_i),
    .retire_tag_i(retire_tag_i), .br_state_i(br_state_i), .rc_head_i(rc_head_i),
    .free_tag_o(free_tag_o), .head_o(head_o), .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mem[i] = 6'(32 + i);
    mhead = 6'd0;
    mtail = 6'd32;
    exp_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkValue({tag, "_tag"},   32'(free_tag_o), 32'd32);
    checkValue({tag, "_head"},  32'(head_o),     32'd0);
    checkValue({tag, "_count"}, 32'(count_o),    32'd32);
    checkValue({tag, "_empty"}, 32'(empty_o),    32'd0);
  endtask

  task automatic checkOutput(input string tag);
    logic [5:0] mcount;
    mcount = mtail - mhead;
    checkValue({tag, "_head"},  32'(head_o),  32'(mhead));
    checkValue({tag, "_count"}, 32'(count_o), 32'(mcount));
    checkValue({tag, "_empty"}, 32'(empty_o), 32'(mhead == mtail));
    if (mhead != mtail)
      checkValue({tag, "_tag"}, 32'(free_tag_o), 32'(mem[mhead[4:0]]));
  endtask

  task automatic applyStimulus(input logic d, input logic r, input logic [5:0] tg,
                               input logic [1:0] br, input logic [5:0] rc, input string tag);
    logic [5:0] granted;
    logic       rec;
    @(negedge clk);
    dispatch_en_i = d;
    retire_en_i   = r;
    retire_tag_i  = tg;
    br_state_i    = br;
    rc_head_i     = rc;
    rec = (br == 2'(BR_PR_WRONG));
    #1;
    if (d && (mhead != mtail) && !rec) exp_q.push_back(mem[mhead[4:0]]);
    if (exp_q.size() > 0) begin
      granted = exp_q.pop_front();
      checkValue({tag, "_grant"}, 32'(free_tag_o), 32'(granted));
    end
    @(posedge clk);
    if (rec) mhead = rc;
    else if (d && (mhead != mtail)) mhead = mhead + 6'd1;
    if (r) begin
      mem[mtail[4:0]] = tg;
      mtail = mtail + 6'd1;
    end
    #1;
    dispatch_en_i = 1'b0;
    retire_en_i   = 1'b0;
    br_state_i    = 2'd0;
    checkOutput(tag);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelReset();
    checkResetValues("rst_low");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_rel");
  endtask

  initial begin
    // Clean falling edge on reset, checked while still held low.
    #1 rst = 1'b0;
    modelReset();
    #2;
    checkResetValues("reset_hold");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("reset_rel");

    // Drain the whole list, tags must come out 32..63 in order.
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "drain");
    checkValue("drain_empty", 32'(empty_o), 32'd1);
    checkValue("drain_count", 32'(count_o), 32'd0);
    checkValue("drain_head",  32'(head_o),  32'd32);
    applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "drain33");
    checkValue("drain33_head", 32'(head_o), 32'd32);

    // From empty, dispatch and retire together: only the push happens.
    applyStimulus(1'b1, 1'b1, 6'd5, 2'd0, 6'd0, "empty_both");
    checkValue("empty_both_empty", 32'(empty_o), 32'd0);
    checkValue("empty_both_tag",   32'(free_tag_o), 32'd5);
    checkValue("empty_both_count", 32'(count_o), 32'd1);
    applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "empty_pop");

    // Misprediction rollback.
    pulseReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "pre_br");
    cap_head = head_o;
    checkValue("br_capture", 32'(cap_head), 32'd3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "spec");
    applyStimulus(1'b1, 1'b0, 6'd0, 2'(BR_PR_WRONG), cap_head, "recover");
    checkValue("recover_head",  32'(head_o),     32'd3);
    checkValue("recover_tag",   32'(free_tag_o), 32'd35);
    checkValue("recover_count", 32'(count_o),    32'd29);
    applyStimulus(1'b0, 1'b0, 6'd0, 2'(BR_PR_CORRECT), 6'd20, "br_correct");
    applyStimulus(1'b0, 1'b0, 6'd0, 2'd3, 6'd20, "br_other");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "spec2");
    applyStimulus(1'b0, 1'b1, 6'd1, 2'(BR_PR_WRONG), cap_head, "recover_push");
    checkValue("recover_push_head",  32'(head_o),  32'd3);
    checkValue("recover_push_count", 32'(count_o), 32'd30);

    // Recycle granted tags across the index 31->0 boundary.
    for (int k = 0; k < 40; k++) begin
      t = mem[mhead[4:0]];
      applyStimulus(1'b1, 1'b1, t, 2'd0, 6'd0, "wrap");
    end
    checkValue("wrap_head",  32'(head_o),  32'd43);
    checkValue("wrap_count", 32'(count_o), 32'd30);

    // Reset lands in the middle of a simultaneous pop and push.
    @(negedge clk);
    dispatch_en_i = 1'b1;
    retire_en_i   = 1'b1;
    retire_tag_i  = mem[mhead[4:0]];
    #2 rst = 1'b0;
    #1;
    checkResetValues("midrst");
    modelReset();
    @(negedge clk);
    dispatch_en_i = 1'b0;
    retire_en_i   = 1'b0;
    checkResetValues("midrst_hold");
    rst = 1'b1;
    #1;
    checkOutput("midrst_rel");
    applyStimulus(1'b1, 1'b0, 6'd0, 2'd0, 6'd0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
